// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// The winner's operands are registered and drive the ALU for one cycle. The result returns as a registered, tagged response.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  I_clk,
    input  logic                  I_rstn,
    input  logic [NUM_REQ-1:0]    I_req_valid,
    output logic [NUM_REQ-1:0]    O_req_ready,
    input  logic [4*NUM_REQ-1:0]  I_req_alusel,
    input  logic [32*NUM_REQ-1:0] I_req_data1,
    input  logic [32*NUM_REQ-1:0] I_req_data2,
    output logic [3:0]            O_alusel,
    output logic [31:0]           O_data1,
    output logic [31:0]           O_data2,
    input  logic [31:0]           I_alu_data,
    input  logic                  I_alu_illegal,
    output logic                  O_rsp_valid,
    output logic [ID_W-1:0]       O_rsp_id,
    output logic [31:0]           O_rsp_data,
    output logic                  O_rsp_illegal,
    input  logic                  I_rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] tag;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic [3:0]      op_alusel;
    logic [31:0]     op_data1;
    logic [31:0]     op_data2;
    logic [3:0]      win_alusel;
    logic [31:0]     win_data1;
    logic [31:0]     win_data2;

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        int cand;
        cand   = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && |(I_req_valid & (NUM_REQ'(1) << cand))) begin
                found  = 1'b1;
                winner = ID_W'(cand);
            end
        end
    end

    // Reset gating keeps ready low while the reset is held, even with valids high.
    assign can_accept = I_rstn && ((state == IDLE) || (state == RESP && I_rsp_ready));
    assign accept     = found && can_accept;

    always_comb begin
        O_req_ready = '0;
        if (accept) begin
            O_req_ready = NUM_REQ'(1) << winner;
        end
    end

    always_comb begin
        win_alusel = '0;
        win_data1  = '0;
        win_data2  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                win_alusel = I_req_alusel[4*k +: 4];
                win_data1  = I_req_data1[32*k +: 32];
                win_data2  = I_req_data2[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = RESP;
            RESP:    if (I_rsp_ready) state_nx = accept ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state         <= IDLE;
            ptr           <= ID_W'(NUM_REQ - 1);
            tag           <= '0;
            op_alusel     <= '0;
            op_data1      <= '0;
            op_data2      <= '0;
            O_rsp_valid   <= 1'b0;
            O_rsp_id      <= '0;
            O_rsp_data    <= '0;
            O_rsp_illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_alusel <= win_alusel;
                op_data1  <= win_data1;
                op_data2  <= win_data2;
                tag       <= winner;
                ptr       <= winner;
            end
            if (state == ISSUE) begin
                O_rsp_valid   <= 1'b1;
                O_rsp_id      <= tag;
                O_rsp_data    <= I_alu_data;
                O_rsp_illegal <= I_alu_illegal;
            end else if (state == RESP && I_rsp_ready) begin
                O_rsp_valid <= 1'b0;
            end
        end
    end

    // The ALU inputs hold the last operation outside ISSUE.
    assign O_alusel = op_alusel;
    assign O_data1  = op_data1;
    assign O_data2  = op_data2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised self-checking bench for alu_arbiter with a transaction-level reference model.
// The bench also stands in for the combinational ALU.
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SLL = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_BAD = 4'hF;

    logic                  I_clk = 1'b0;
    logic                  I_rstn = 1'b0;
    logic [NUM_REQ-1:0]    I_req_valid = '0;
    logic [NUM_REQ-1:0]    O_req_ready;
    logic [4*NUM_REQ-1:0]  I_req_alusel = '0;
    logic [32*NUM_REQ-1:0] I_req_data1 = '0;
    logic [32*NUM_REQ-1:0] I_req_data2 = '0;
    logic [3:0]            O_alusel;
    logic [31:0]           O_data1;
    logic [31:0]           O_data2;
    logic [31:0]           I_alu_data;
    logic                  I_alu_illegal;
    logic                  O_rsp_valid;
    logic [ID_W-1:0]       O_rsp_id;
    logic [31:0]           O_rsp_data;
    logic                  O_rsp_illegal;
    logic                  I_rsp_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        int          id;
    } op_t;

    // Reference model: one op may be in the ALU, one response may be waiting.
    bit              m_inflight;
    bit              m_rsp_out;
    int              m_last;
    op_t             m_op;
    logic [31:0]     m_rsp_data;
    logic            m_rsp_ill;
    int              m_rsp_id;
    logic [NUM_REQ-1:0] obs_ready;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .I_clk         (I_clk),
        .I_rstn        (I_rstn),
        .I_req_valid   (I_req_valid),
        .O_req_ready   (O_req_ready),
        .I_req_alusel  (I_req_alusel),
        .I_req_data1   (I_req_data1),
        .I_req_data2   (I_req_data2),
        .O_alusel      (O_alusel),
        .O_data1       (O_data1),
        .O_data2       (O_data2),
        .I_alu_data    (I_alu_data),
        .I_alu_illegal (I_alu_illegal),
        .O_rsp_valid   (O_rsp_valid),
        .O_rsp_id      (O_rsp_id),
        .O_rsp_data    (O_rsp_data),
        .O_rsp_illegal (O_rsp_illegal),
        .I_rsp_ready   (I_rsp_ready)
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [32:0] alu_ref(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        r   = '0;
        ill = 1'b0;
        case (sel)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a << b[4:0];
            4'h3: r = a >> b[4:0];
            4'h4: r = $signed(a) >>> b[4:0];
            4'h5: r = a & b;
            4'h6: r = a | b;
            4'h7: r = a ^ b;
            4'h8: r = {31'b0, $signed(a) < $signed(b)};
            4'h9: r = {31'b0, a < b};
            default: begin
                ill = 1'b1;
                r   = a ^ 32'hA5A5_5A5A;
            end
        endcase
        return {ill, r};
    endfunction

    assign {I_alu_illegal, I_alu_data} = alu_ref(O_alusel, O_data1, O_data2);

    task automatic set_req(input int k, input logic v, input logic [3:0] sel,
                           input logic [31:0] a, input logic [31:0] b);
        I_req_valid[k]           = v;
        I_req_alusel[4*k +: 4]   = sel;
        I_req_data1[32*k +: 32]  = a;
        I_req_data2[32*k +: 32]  = b;
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_rsp_out  = 0;
        m_last     = NUM_REQ - 1;
        m_op       = '{sel: 4'h0, a: 32'h0, b: 32'h0, id: 0};
        m_rsp_data = '0;
        m_rsp_ill  = 1'b0;
        m_rsp_id   = 0;
    endtask

    // One clock: check ready against the model, advance the model at the edge, check the outputs.
    task automatic run_cycle();
        logic [NUM_REQ-1:0] exp_ready;
        bit                 can;
        int                 win;
        logic [32:0]        res;
        #1;
        can = !m_inflight && (!m_rsp_out || I_rsp_ready);
        win = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_last + k) % NUM_REQ;
            if (win < 0 && I_req_valid[c]) win = c;
        end
        exp_ready = '0;
        if (can && win >= 0) exp_ready[win] = 1'b1;
        obs_ready = O_req_ready;
        n_cmp++;
        if (O_req_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL ready @%0t: got %b want %b", $time, O_req_ready, exp_ready);
        end
        @(posedge I_clk);
        if (m_inflight) begin
            res        = alu_ref(m_op.sel, m_op.a, m_op.b);
            m_rsp_ill  = res[32];
            m_rsp_data = res[31:0];
            m_rsp_id   = m_op.id;
            m_rsp_out  = 1;
        end else if (m_rsp_out && I_rsp_ready) begin
            m_rsp_out = 0;
        end
        m_inflight = (exp_ready != '0);
        if (m_inflight) begin
            m_op.sel = I_req_alusel[4*win +: 4];
            m_op.a   = I_req_data1[32*win +: 32];
            m_op.b   = I_req_data2[32*win +: 32];
            m_op.id  = win;
            m_last   = win;
        end
        #1;
        n_cmp++;
        if (O_rsp_valid !== m_rsp_out) begin
            n_bad++;
            $display("FAIL rsp_valid @%0t: got %b want %b", $time, O_rsp_valid, m_rsp_out);
        end
        if (m_rsp_out) begin
            n_cmp++;
            if (O_rsp_data !== m_rsp_data || O_rsp_illegal !== m_rsp_ill ||
                O_rsp_id !== ID_W'(m_rsp_id)) begin
                n_bad++;
                $display("FAIL rsp @%0t: got data=%h ill=%b id=%0d want data=%h ill=%b id=%0d",
                         $time, O_rsp_data, O_rsp_illegal, O_rsp_id, m_rsp_data, m_rsp_ill, m_rsp_id);
            end
        end
        n_cmp++;
        if (O_alusel !== m_op.sel || O_data1 !== m_op.a || O_data2 !== m_op.b) begin
            n_bad++;
            $display("FAIL alu_operands @%0t: got %h/%h/%h want %h/%h/%h", $time,
                     O_alusel, O_data1, O_data2, m_op.sel, m_op.a, m_op.b);
        end
        @(negedge I_clk);
    endtask

    task automatic drain();
        for (int k = 0; k < NUM_REQ; k++) I_req_valid[k] = 1'b0;
        I_rsp_ready = 1'b1;
        repeat (3) run_cycle();
    endtask

    task automatic test_reset();
        I_rstn = 1'b0;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        repeat (2) @(negedge I_clk);
        #1;
        n_cmp++;
        if (O_req_ready !== '0 || O_rsp_valid !== 1'b0 || O_rsp_illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b ill=%b want 0", O_req_ready,
                     O_rsp_valid, O_rsp_illegal);
        end
        n_cmp++;
        if (O_rsp_id !== '0 || O_rsp_data !== '0 || O_alusel !== '0 || O_data1 !== '0 ||
            O_data2 !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got id=%0d data=%h sel=%h d1=%h d2=%h want all 0",
                     O_rsp_id, O_rsp_data, O_alusel, O_data1, O_data2);
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge I_clk);
        I_rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_single_add();
        I_rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        run_cycle();
        n_cmp++;
        if (obs_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL add_grant: got %b want 01", obs_ready);
        end
        set_req(0, 1'b0, OP_ADD, 32'd5, 32'd7);
        run_cycle();
        n_cmp++;
        if (O_rsp_valid !== 1'b1 || O_rsp_data !== 32'd12 || O_rsp_id !== 1'b0 ||
            O_rsp_illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL add_rsp: got v=%b data=%0d id=%0d ill=%b want v=1 data=12 id=0 ill=0",
                     O_rsp_valid, O_rsp_data, O_rsp_id, O_rsp_illegal);
        end
        drain();
    endtask

    task automatic test_alternate();
        int nrsp;
        int expect_id;
        nrsp      = 0;
        expect_id = 1;  // requester 0 won last, so requester 1 is next in line
        I_rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3);
        set_req(1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        repeat (8) begin
            run_cycle();
            if (O_rsp_valid === 1'b1) begin
                n_cmp++;
                if (O_rsp_id !== ID_W'(expect_id) ||
                    O_rsp_data !== ((expect_id == 1) ? 32'hFF : 32'd7)) begin
                    n_bad++;
                    $display("FAIL alt_rsp: got id=%0d data=%h want id=%0d", O_rsp_id,
                             O_rsp_data, expect_id);
                end
                expect_id ^= 1;
                nrsp++;
            end
        end
        n_cmp++;
        if (nrsp != 4) begin
            n_bad++;
            $display("FAIL alt_throughput: got %0d responses want 4", nrsp);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0]     held_data;
        logic [ID_W-1:0] held_id;
        logic            held_ill;
        I_rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, $urandom, $urandom);
        run_cycle();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        run_cycle();
        held_data = O_rsp_data;
        held_id   = O_rsp_id;
        held_ill  = O_rsp_illegal;
        I_rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_SUB, $urandom, $urandom);
        set_req(1, 1'b1, OP_XOR, $urandom, $urandom);
        repeat (5) begin
            run_cycle();
            n_cmp++;
            if (obs_ready !== '0 || O_rsp_valid !== 1'b1 || O_rsp_data !== held_data ||
                O_rsp_id !== held_id || O_rsp_illegal !== held_ill) begin
                n_bad++;
                $display("FAIL bp_hold: got ready=%b v=%b data=%h id=%0d want ready=00 v=1 data=%h id=%0d",
                         obs_ready, O_rsp_valid, O_rsp_data, O_rsp_id, held_data, held_id);
            end
        end
        I_rsp_ready = 1'b1;
        run_cycle();
        n_cmp++;
        if (obs_ready !== 2'b10 || O_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: got ready=%b v=%b want ready=10 v=0", obs_ready,
                     O_rsp_valid);
        end
        drain();
    endtask

    task automatic test_illegal();
        I_rsp_ready = 1'b1;
        set_req(1, 1'b1, OP_BAD, $urandom, $urandom);
        run_cycle();
        set_req(1, 1'b1, OP_ADD, 32'd3, 32'd4);
        run_cycle();
        n_cmp++;
        if (O_rsp_valid !== 1'b1 || O_rsp_illegal !== 1'b1 || O_rsp_id !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_rsp: got v=%b ill=%b id=%0d want v=1 ill=1 id=1", O_rsp_valid,
                     O_rsp_illegal, O_rsp_id);
        end
        run_cycle();
        set_req(1, 1'b0, OP_ADD, 32'd3, 32'd4);
        run_cycle();
        n_cmp++;
        if (O_rsp_valid !== 1'b1 || O_rsp_illegal !== 1'b0 || O_rsp_data !== 32'd7) begin
            n_bad++;
            $display("FAIL illegal_clear: got v=%b ill=%b data=%0d want v=1 ill=0 data=7",
                     O_rsp_valid, O_rsp_illegal, O_rsp_data);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        I_rsp_ready = 1'b1;
        set_req(0, 1'b1, OP_SLL, 32'd1, 32'd4);
        run_cycle();
        set_req(0, 1'b1, OP_ADD, 32'd2, 32'd2);
        set_req(1, 1'b1, OP_ADD, 32'd9, 32'd9);
        #1;
        I_rstn = 1'b0;
        #1;
        n_cmp++;
        if (O_alusel !== '0 || O_data1 !== '0 || O_data2 !== '0 || O_rsp_valid !== 1'b0 ||
            O_req_ready !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got sel=%h d1=%h d2=%h v=%b ready=%b want all 0",
                     O_alusel, O_data1, O_data2, O_rsp_valid, O_req_ready);
        end
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge I_clk);
        I_rstn = 1'b1;
        model_reset();
        repeat (3) begin
            run_cycle();
            n_cmp++;
            if (O_rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_rsp: got v=%b want 0", O_rsp_valid);
            end
        end
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(1, 1'b1, OP_ADD, 32'd3, 32'd4);
        run_cycle();
        n_cmp++;
        if (obs_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_priority: got %b want 01", obs_ready);
        end
        drain();
    endtask

    task automatic test_single_requester();
        int grants;
        int cycles;
        grants = 0;
        cycles = 0;
        I_rsp_ready = 1'b1;
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'($urandom_range(0, 9)), $urandom, $urandom);
        while (grants < 10 && cycles < 40) begin
            run_cycle();
            cycles++;
            n_cmp++;
            if (obs_ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL spurious_grant0: got %b want 0", obs_ready[0]);
            end
            if (obs_ready[1] === 1'b1) begin
                grants++;
                set_req(1, grants < 10, 4'($urandom_range(0, 9)), $urandom, $urandom);
            end
        end
        n_cmp++;
        if (grants != 10 || cycles != 19) begin
            n_bad++;
            $display("FAIL req1_stream: got %0d grants in %0d cycles want 10 in 19", grants, cycles);
        end
        drain();
    endtask

    task automatic test_random();
        repeat (400) begin
            I_rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!I_req_valid[k] && $urandom_range(0, 2) == 0)
                    set_req(k, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
                else if (I_req_valid[k] && $urandom_range(0, 15) == 0)
                    I_req_valid[k] = 1'b0;
            end
            run_cycle();
            for (int k = 0; k < NUM_REQ; k++) begin
                if (obs_ready[k] === 1'b1) I_req_valid[k] = 1'b0;
            end
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_add();
        test_alternate();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_single_requester();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
